// File: rtl/pendulum_pkg.sv
// -----------------------------------------------------------------------------
// pendulum_pkg
//   Types, constants and helpers shared across the pendulum datapath
//   (encoder_velocity, moving_avg4, pwm input clamping).
//
//   vel_state_t       : estimator control states (IDLE / PRIME / RUN)
//   DEF_WINDOW_TICKS  : default sample window, 1 ms at CLOCK_50
//   DELTA_W / SUM_W   : width of a raw position delta / of the 4-term sum
//   sat_to_w()        : clamp a signed SUM_W value to a signed w-bit range;
//                       the result is still SUM_W wide, so callers can compare
//                       it against the input to detect clipping and then
//                       truncate to w bits.
// -----------------------------------------------------------------------------
package pendulum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } vel_state_t;

   localparam int DEF_WINDOW_TICKS = 50000;
   localparam int DELTA_W          = 32;
   localparam int SUM_W            = 34;

   function automatic logic signed [SUM_W-1:0] sat_to_w(
      input logic signed [SUM_W-1:0] x,
      input int                      w
   );
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      hi = (34'sd1 <<< (w - 1)) - 34'sd1;
      lo = -hi - 34'sd1;
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/moving_avg4.sv
// -----------------------------------------------------------------------------
// moving_avg4
//   Four-window moving average of signed 32-bit deltas.
//   A 4-deep delay line feeds a running 34-bit sum (add newest, drop oldest);
//   the mean is sum >>> 2 (floor), clamped to VEL_W bits and registered one
//   cycle after the sum, so out/full trail in_valid by two clocks.
//
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   flush     in   empties the delay line, zeroes sum and fill, drops full
//   in_valid  in   one-cycle strobe qualifying in
//   in        in   signed 32-bit delta
//   out       out  signed, saturated mean of the last 4 deltas
//   full      out  level, high once 4 deltas are held
// -----------------------------------------------------------------------------
module moving_avg4
   import pendulum_pkg::*;
#(
   parameter int VEL_W = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic signed [DELTA_W-1:0] in,
   output logic signed [VEL_W-1:0]   out,
   output logic                      full
);

   logic signed [DELTA_W-1:0] dly_q [4];
   logic signed [SUM_W-1:0]   sum_q;
   logic signed [SUM_W-1:0]   in_ext;
   logic signed [SUM_W-1:0]   old_ext;
   logic [2:0]                fill_q;
   logic                      vld_p1;
   logic signed [VEL_W-1:0]   out_p2;
   logic                      full_p2;

   assign in_ext  = {{(SUM_W-DELTA_W){in[DELTA_W-1]}}, in};
   assign old_ext = {{(SUM_W-DELTA_W){dly_q[3][DELTA_W-1]}}, dly_q[3]};

   // ---- stage p1: delay line, running sum, fill count ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            dly_q[i] <= '0;
         end
         sum_q  <= '0;
         fill_q <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid && !flush;
         if (flush) begin
            for (int i = 0; i < 4; i++) begin
               dly_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= '0;
         end else if (in_valid) begin
            dly_q[0] <= in;
            for (int i = 1; i < 4; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
            // empty slots hold zero, so subtracting the oldest is safe while filling
            sum_q <= sum_q + in_ext - old_ext;
            if (fill_q != 3'd4) begin
               fill_q <= fill_q + 3'd1;
            end
         end
      end
   end

   // ---- stage p2: mean and fill flag ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_p2  <= '0;
         full_p2 <= 1'b0;
      end else begin
         // an update already in flight completes even if a flush arrives now
         if (vld_p1) begin
            out_p2 <= VEL_W'(sat_to_w(sum_q >>> 2, VEL_W));
         end
         if (flush) begin
            full_p2 <= 1'b0;
         end else if (vld_p1) begin
            full_p2 <= (fill_q == 3'd4);
         end
      end
   end

   assign out  = out_p2;
   assign full = full_p2;

endmodule

// File: rtl/encoder_velocity.sv
// -----------------------------------------------------------------------------
// encoder_velocity
//   Velocity estimator on the quadrature encoder's 32-bit position count.
//   Every WINDOW_TICKS clocks the count is captured and the signed modular
//   delta against the previous capture is produced, saturated to VEL_W bits,
//   averaged over 4 windows and watched for a stalled shaft.
//   The first window after enable/clear only captures the baseline.
//
//   clk        in   system clock (CLOCK_50)
//   reset_n    in   asynchronous active-low reset
//   enable     in   runs the estimator; low forces IDLE
//   clear      in   synchronous restart: re-prime baseline, empty average
//   count_in   in   encoder position count, two's complement, free wrapping
//   vel        out  signed saturated delta of the last window     (T+1)
//   vel_avg    out  signed saturated mean of the last 4 deltas    (T+2)
//   vel_valid  out  one-cycle pulse when vel updates              (T+1)
//   avg_valid  out  level, 4 deltas held in the average           (T+2)
//   sat        out  last vel was clipped                          (T+1)
//   stall      out  STALL_WIN consecutive zero deltas seen        (T+1)
// -----------------------------------------------------------------------------
module encoder_velocity
   import pendulum_pkg::*;
#(
   parameter int WINDOW_TICKS = DEF_WINDOW_TICKS,
   parameter int VEL_W        = 16,
   parameter int STALL_WIN    = 100
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [31:0]             count_in,
   output logic signed [VEL_W-1:0] vel,
   output logic signed [VEL_W-1:0] vel_avg,
   output logic                    vel_valid,
   output logic                    avg_valid,
   output logic                    sat,
   output logic                    stall
);

   localparam int CNT_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
   localparam int STL_W = $clog2(STALL_WIN + 1);
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(WINDOW_TICKS - 1);
   localparam logic [STL_W-1:0] STALL_MAX = STL_W'(STALL_WIN);

   vel_state_t state_q;
   vel_state_t state_d;

   logic [CNT_W-1:0] win_cnt_q;
   logic [CNT_W-1:0] win_cnt_d;
   logic             terminal;
   logic             tick_prime;
   logic             tick_run;
   logic             flush;

   logic [DELTA_W-1:0]        prev_q;
   logic signed [DELTA_W-1:0] delta_p0;
   logic signed [SUM_W-1:0]   delta_ext_p0;
   logic signed [SUM_W-1:0]   vel_sat_p0;
   logic [STL_W-1:0]          stall_cnt_q;
   logic [STL_W-1:0]          stall_cnt_d;

   logic signed [VEL_W-1:0] vel_p1;
   logic                    sat_p1;
   logic                    stall_p1;
   logic                    vld_p1;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         win_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (clear) begin
         state_d = ST_PRIME;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: if (terminal) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      terminal   = (win_cnt_q == LAST_TICK);
      tick_prime = 1'b0;
      tick_run   = 1'b0;
      // clear beats a coincident terminal tick
      if (enable && !clear && terminal) begin
         tick_prime = (state_q == ST_PRIME);
         tick_run   = (state_q == ST_RUN);
      end
      flush = !enable || clear || (state_q == ST_IDLE);
      if (!enable || clear || (state_q == ST_IDLE) || terminal) begin
         win_cnt_d = '0;
      end else begin
         win_cnt_d = win_cnt_q + CNT_W'(1);
      end
   end

   // ---- stage p0: modular delta, saturation, zero-run count ----
   // 32-bit modular subtraction makes a wrap of the position count invisible
   assign delta_p0     = $signed(count_in - prev_q);
   assign delta_ext_p0 = {{(SUM_W-DELTA_W){delta_p0[DELTA_W-1]}}, delta_p0};
   assign vel_sat_p0   = sat_to_w(delta_ext_p0, VEL_W);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (delta_p0 == '0) begin
         if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + STL_W'(1);
         end
      end else begin
         stall_cnt_d = '0;
      end
   end

   // ---- stage p1: registered velocity, flags and strobe ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q      <= '0;
         vel_p1      <= '0;
         sat_p1      <= 1'b0;
         stall_p1    <= 1'b0;
         stall_cnt_q <= '0;
         vld_p1      <= 1'b0;
      end else begin
         vld_p1 <= tick_run;
         if (tick_prime || tick_run) begin
            prev_q <= count_in;
         end
         if (tick_run) begin
            vel_p1 <= VEL_W'(vel_sat_p0);
            sat_p1 <= (vel_sat_p0 != delta_ext_p0);
         end
         if (clear) begin
            stall_cnt_q <= '0;
            stall_p1    <= 1'b0;
         end else if (tick_run) begin
            stall_cnt_q <= stall_cnt_d;
            stall_p1    <= (stall_cnt_d == STALL_MAX);
         end
      end
   end

   assign vel       = vel_p1;
   assign sat       = sat_p1;
   assign stall     = stall_p1;
   assign vel_valid = vld_p1;

   // ---- stages p1/p2: moving average (unsaturated delta in, mean out) ----
   moving_avg4 #(
      .VEL_W (VEL_W)
   ) u_avg (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .in_valid (tick_run),
      .in       (delta_p0),
      .out      (vel_avg),
      .full     (avg_valid)
   );

endmodule

// File: tb/tb_encoder_velocity.sv
// -----------------------------------------------------------------------------
// tb_encoder_velocity
//   Scoreboard bench: each window's terminal count is driven by the window
//   task, which pushes the expected velocity/flags/average and the cycle at
//   which vel_valid must appear; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_encoder_velocity;

   localparam int W  = 100;
   localparam int VW = 16;
   localparam int SW = 3;

   logic                 clk      = 1'b0;
   logic                 reset_n  = 1'b1;
   logic                 enable   = 1'b0;
   logic                 clear    = 1'b0;
   logic [31:0]          count_in = 32'd0;
   logic signed [VW-1:0] vel;
   logic signed [VW-1:0] vel_avg;
   logic                 vel_valid;
   logic                 avg_valid;
   logic                 sat;
   logic                 stall;

   encoder_velocity #(
      .WINDOW_TICKS (W),
      .VEL_W        (VW),
      .STALL_WIN    (SW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .clear     (clear),
      .count_in  (count_in),
      .vel       (vel),
      .vel_avg   (vel_avg),
      .vel_valid (vel_valid),
      .avg_valid (avg_valid),
      .sat       (sat),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int cyc;
      int vel;
      bit sat;
      bit stall;
      int avg;
      bit avg_v;
   } exp_t;

   exp_t        sb[$];
   int          hist[$];
   logic [31:0] prev_m   = 32'd0;
   int          zc       = 0;
   int          last_vel = 0;

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   function automatic int clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   task automatic push_expected(input logic [31:0] term);
      exp_t   e;
      int     d;
      longint s;
      longint q;
      d      = int'(term - prev_m);
      prev_m = term;
      e.cyc  = cyc + 1;
      e.vel  = clamp16(d);
      e.sat  = (e.vel != d);
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      q = s / 4;
      if (s < 0 && (s % 4) != 0) q = q - 1;
      e.avg   = clamp16(q);
      e.avg_v = (hist.size() == 4);
      zc      = (d == 0) ? ((zc < SW) ? zc + 1 : SW) : 0;
      e.stall = (zc == SW);
      last_vel = e.vel;
      sb.push_back(e);
   endtask

   // One sample window of W clocks. The terminal value is driven in the last
   // cycle; ramp mode instead steps count_in by +3 every 10 clocks.
   task automatic window(input bit ramp, input logic [31:0] mid,
                         input logic [31:0] term, input bit prime,
                         input bit do_clear);
      for (int j = 1; j <= W; j++) begin
         @(negedge clk);
         clear = 1'b0;
         if (ramp) begin
            if (j % 10 == 0) count_in = count_in + 32'd3;
         end else if (j == W / 2) begin
            count_in = mid;
         end
         if (prime && j == 3) check_eq("prime_avg_valid", avg_valid, 0);
         if (j == W) begin
            if (!ramp) count_in = term;
            if (do_clear) begin
               clear = 1'b1;
               hist.delete();
               zc = 0;
            end else if (prime) begin
               prev_m = count_in;
            end else begin
               push_expected(count_in);
            end
         end
      end
   endtask

   // Output monitor
   exp_t pend;
   bit   avg_pend = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (avg_pend) begin
               check_eq("avg_valid", avg_valid, pend.avg_v);
               if (pend.avg_v) check_eq("vel_avg", vel_avg, pend.avg);
               avg_pend = 1'b0;
            end
            if (vel_valid) begin
               check_eq("pending_at_valid", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  pend = sb.pop_front();
                  check_eq("valid_cycle", cyc, pend.cyc);
                  check_eq("vel", vel, pend.vel);
                  check_eq("sat", sat, pend.sat);
                  check_eq("stall", stall, pend.stall);
                  avg_pend = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      #2 reset_n = 1'b0;
      @(negedge clk);
      check_eq("rst_vel", vel, 0);
      check_eq("rst_vel_avg", vel_avg, 0);
      check_eq("rst_vel_valid", vel_valid, 0);
      check_eq("rst_avg_valid", avg_valid, 0);
      check_eq("rst_sat", sat, 0);
      check_eq("rst_stall", stall, 0);
      repeat (3) @(negedge clk);
      reset_n  = 1'b1;
      count_in = 32'd1000;

      // ramp +3 / 10 clocks: vel 30, average valid from the 4th pulse
      @(negedge clk);
      enable = 1'b1;
      window(1, 0, 0, 1, 0);
      repeat (5) window(1, 0, 0, 0, 0);

      // wrap through 0 and through the 0x80000000 sign boundary
      window(0, 32'h0000_1000, 32'hFFFF_FFF0, 0, 0);
      window(0, 32'hFFFF_FFFE, 32'h0000_000A, 0, 0);
      window(0, 32'h4000_0000, 32'h7FFF_FFF0, 0, 0);
      window(0, 32'h7FFF_FFFF, 32'h8000_000A, 0, 0);

      // saturation both ways
      window(0, count_in, count_in + 32'd40000, 0, 0);
      window(0, count_in, count_in - 32'd40000, 0, 0);

      // -1,-1,-1,-2 -> floor(-5/4) = -2
      repeat (3) window(0, count_in, count_in - 32'd1, 0, 0);
      window(0, count_in, count_in - 32'd2, 0, 0);

      // stalled shaft, then one nonzero delta
      repeat (4) window(0, count_in + 32'd5, count_in, 0, 0);
      window(0, count_in, count_in + 32'd1, 0, 0);

      // clear on the terminal tick, re-prime, refill the average
      window(0, count_in, count_in + 32'd9, 0, 1);
      window(0, count_in, count_in + 32'd5, 1, 0);
      repeat (4) window(0, count_in, count_in + 32'd7, 0, 0);

      // idle: outputs hold, average is emptied, no pulses
      repeat (20) @(negedge clk);
      enable = 1'b0;
      hist.delete();
      repeat (2 * W) @(negedge clk);
      check_eq("idle_vel_hold", vel, last_vel);
      check_eq("idle_avg_valid", avg_valid, 0);
      check_eq("idle_vel_valid", vel_valid, 0);
      @(negedge clk);
      enable = 1'b1;
      window(0, count_in, count_in + 32'd11, 1, 0);
      repeat (2) window(0, count_in, count_in + 32'd12, 0, 0);

      // asynchronous reset mid-window
      repeat (W / 2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_vel", vel, 0);
      check_eq("mid_rst_vel_avg", vel_avg, 0);
      check_eq("mid_rst_vel_valid", vel_valid, 0);
      check_eq("mid_rst_avg_valid", avg_valid, 0);
      check_eq("mid_rst_sat", sat, 0);
      check_eq("mid_rst_stall", stall, 0);
      @(negedge clk);
      enable  = 1'b0;
      reset_n = 1'b1;
      prev_m  = 32'd0;
      hist.delete();
      zc = 0;
      @(negedge clk);
      enable = 1'b1;
      window(0, count_in, 32'd500, 1, 0);
      window(0, count_in, 32'd530, 0, 0);

      repeat (5) @(negedge clk);
      check_eq("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
